fqmul_pipe: RTL and testbench

//  Pipelined, multi-lane Montgomery modular multiplier for the Dilithium NTT/pointwise datapath.

---
 rtl/fqmul_pkg.sv | 24 ++
 rtl/mont_reduce_pipe.sv | 88 ++++++++
 rtl/fqmul_pipe.sv | 102 ++++++++++
 tb/tb_fqmul_pipe.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fqmul_pkg.sv
// Shared constants and helpers for the Dilithium Montgomery multiplier pipeline.
// FQMUL_PIPE_CANON_EN adds a final stage that folds results into [0, Q).
package fqmul_pkg;

    localparam int DIL_Q     = 8380417;
    localparam int DIL_QINV  = 58728449;
    localparam int DIL_MONT  = 4193792;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_TAG_W = 4;

`ifdef FQMUL_PIPE_CANON_EN
    localparam int RED_STAGES = 4;
`else
    localparam int RED_STAGES = 3;
`endif

    // Total register levels from operand capture to out_r (S1 plus reduction).
    localparam int PIPE_STAGES = RED_STAGES + 1;

    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/mont_reduce_pipe.sv
// One lane of Montgomery reduction (S2..S4, plus S5 when FQMUL_PIPE_CANON_EN is defined)
// applied to a signed 2*WIDTH product; all stages share a single advance enable.
module mont_reduce_pipe
    import fqmul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int Q     = DIL_Q,
    parameter int QINV  = DIL_QINV
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      en,
    input  logic signed [2*WIDTH-1:0] p_in,
    output logic signed [WIDTH-1:0]   r_out
);

    localparam logic [WIDTH-1:0]          QINV_W = WIDTH'(QINV);
    localparam logic signed [2*WIDTH-1:0] Q_2W   = (2*WIDTH)'(Q);

    logic signed [WIDTH-1:0]   t_q, t_d;
    logic signed [2*WIDTH-1:0] p2_q, p2_d;
    logic signed [2*WIDTH-1:0] p3_q, p3_d;
    logic signed [2*WIDTH-1:0] u_q, u_d;
    logic signed [WIDTH-1:0]   r_q, r_d;
    logic signed [2*WIDTH-1:0] t_ext;
    logic signed [2*WIDTH-1:0] diff;

    assign t_ext = {{WIDTH{t_q[WIDTH-1]}}, t_q};
    // p - t*Q is an exact multiple of 2^WIDTH, so the upper half is the shifted result.
    assign diff  = p3_q - u_q;

    always_comb begin
        t_d  = t_q;
        p2_d = p2_q;
        u_d  = u_q;
        p3_d = p3_q;
        r_d  = r_q;
        if (en) begin
            t_d  = p_in[WIDTH-1:0] * QINV_W;
            p2_d = p_in;
            u_d  = t_ext * Q_2W;
            p3_d = p2_q;
            r_d  = diff[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            t_q  <= '0;
            p2_q <= '0;
            u_q  <= '0;
            p3_q <= '0;
            r_q  <= '0;
        end else begin
            t_q  <= t_d;
            p2_q <= p2_d;
            u_q  <= u_d;
            p3_q <= p3_d;
            r_q  <= r_d;
        end
    end

`ifdef FQMUL_PIPE_CANON_EN
    localparam logic signed [WIDTH-1:0] Q_W = WIDTH'(Q);

    logic signed [WIDTH-1:0] rc_q, rc_d;

    always_comb begin
        rc_d = rc_q;
        if (en) begin
            rc_d = r_q[WIDTH-1] ? (r_q + Q_W) : r_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rc_q <= '0;
        end else begin
            rc_q <= rc_d;
        end
    end

    assign r_out = rc_q;
`else
    assign r_out = r_q;
`endif

endmodule

// File: rtl/fqmul_pipe.sv
// Pipelined multi-lane Montgomery multiplier r = a*b*2^-WIDTH mod Q with a tag sideband.
// Defining FQMUL_PIPE_CANON_EN adds a fifth stage producing canonical results in [0, Q).
module fqmul_pipe
    import fqmul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LANES = 1,
    parameter int TAG_W = DEF_TAG_W,
    parameter int Q     = DIL_Q,
    parameter int QINV  = DIL_QINV
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_r,
    output logic [TAG_W-1:0]       out_tag
);

    localparam int NSTG = PIPE_STAGES;

    logic                       adv;
    logic [NSTG-1:0]            v_q, v_d;
    logic [NSTG-1:0][TAG_W-1:0] tag_q, tag_d;

    // Handshake: a side transfers when valid & ready on the same rising edge. The whole
    // pipe advances as one unit whenever the output slot is empty or being drained, so
    // in_ready is that advance condition and bubbles are carried rather than collapsed.
    assign adv       = ~v_q[NSTG-1] | out_ready;
    assign in_ready  = adv;
    assign out_valid = v_q[NSTG-1];
    assign out_tag   = tag_q[NSTG-1];

    always_comb begin
        v_d   = v_q;
        tag_d = tag_q;
        if (adv) begin
            v_d[0]   = in_valid;
            tag_d[0] = in_tag;
            for (int s = 1; s < NSTG; s++) begin
                v_d[s]   = v_q[s-1];
                tag_d[s] = tag_q[s-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            v_q   <= '0;
            tag_q <= '0;
        end else begin
            v_q   <= v_d;
            tag_q <= tag_d;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [WIDTH-1:0]   a_k, b_k, r_k;
        logic signed [2*WIDTH-1:0] a_ext, b_ext;
        logic signed [2*WIDTH-1:0] p_q, p_d;

        assign a_k   = in_a[lane_lsb(k, WIDTH) +: WIDTH];
        assign b_k   = in_b[lane_lsb(k, WIDTH) +: WIDTH];
        assign a_ext = {{WIDTH{a_k[WIDTH-1]}}, a_k};
        assign b_ext = {{WIDTH{b_k[WIDTH-1]}}, b_k};

        always_comb begin
            p_d = p_q;
            if (adv) begin
                p_d = a_ext * b_ext;
            end
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                p_q <= '0;
            end else begin
                p_q <= p_d;
            end
        end

        mont_reduce_pipe #(
            .WIDTH (WIDTH),
            .Q     (Q),
            .QINV  (QINV)
        ) u_red (
            .clock   (clock),
            .reset_n (reset_n),
            .en      (adv),
            .p_in    (p_q),
            .r_out   (r_k)
        );

        assign out_r[lane_lsb(k, WIDTH) +: WIDTH] = r_k;
    end

endmodule

// File: tb/tb_fqmul_pipe.sv
// Directed bench for fqmul_pipe (four lanes) with an expected-result queue and a
// reference Montgomery model; honours FQMUL_PIPE_CANON_EN for latency and result range.
`timescale 1ns/1ps
module tb_fqmul_pipe;

    localparam int WIDTH = 32;
    localparam int LANES = 4;
    localparam int TAG_W = 4;
    localparam int VW    = WIDTH * LANES;
    localparam int EW    = VW + TAG_W;
    localparam int QC    = 8380417;
    localparam int QINVC = 58728449;
    localparam int MONTC = 4193792;
`ifdef FQMUL_PIPE_CANON_EN
    localparam int LAT   = 5;
    localparam bit CANON = 1'b1;
`else
    localparam int LAT   = 4;
    localparam bit CANON = 1'b0;
`endif

    logic             clock     = 1'b0;
    logic             reset_n   = 1'b0;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b0;
    logic [VW-1:0]    in_a      = '0;
    logic [VW-1:0]    in_b      = '0;
    logic [TAG_W-1:0] in_tag    = '0;
    logic             in_ready;
    logic             out_valid;
    logic [VW-1:0]    out_r;
    logic [TAG_W-1:0] out_tag;

    logic [EW-1:0]    exp_q[$];
    int               checks   = 0;
    int               errors   = 0;
    int               accepted = 0;
    int               out_cnt  = 0;
    int               cyc      = 0;
    logic [TAG_W-1:0] tag_ctr  = '0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    fqmul_pipe #(
        .WIDTH (WIDTH),
        .LANES (LANES),
        .TAG_W (TAG_W),
        .Q     (QC),
        .QINV  (QINVC)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_tag   (out_tag)
    );

    // Reference: the C montgomery_reduce on a 64-bit product.
    function automatic logic [WIDTH-1:0] mont_model(input int a, input int b);
        longint p, u, r;
        int     t;
        p = longint'(a) * longint'(b);
        t = int'(p) * QINVC;
        u = longint'(t) * longint'(QC);
        r = (p - u) >>> 32;
        if (CANON && r < 0) r = r + QC;
        return r[WIDTH-1:0];
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        int            x;
        for (int k = 0; k < LANES; k++) begin
            x = int'($urandom_range(0, 2 * QC - 2)) - (QC - 1);
            v[k*WIDTH +: WIDTH] = x;
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [EW-1:0] obs, input logic [EW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
        end
    endtask

    // Presents one set and holds it until accepted; returns just after the accepting edge.
    task automatic send(input logic [VW-1:0] a, input logic [VW-1:0] b);
        logic [VW-1:0] r;
        bit            done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tag   = tag_ctr;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clock);
            if (in_ready) begin
                for (int k = 0; k < LANES; k++)
                    r[k*WIDTH +: WIDTH] = mont_model($signed(a[k*WIDTH +: WIDTH]),
                                                     $signed(b[k*WIDTH +: WIDTH]));
                exp_q.push_back({tag_ctr, r});
                tag_ctr++;
                accepted++;
                done = 1'b1;
            end
            @(posedge clock);
            #1;
        end
        chk("send_accepted", done, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 300 && exp_q.size() != 0; n++) begin
            @(posedge clock);
            #1;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    always @(negedge clock) begin
        logic [EW-1:0] e;
        if (reset_n && out_valid && out_ready) begin
            out_cnt++;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_out observed=%0h expected=none", {out_tag, out_r});
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_data", {out_tag, out_r}, e);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0] a, b;
        int            cnt, start, out0;
        bit            done5;

        // Reset state
        out_ready = 1'b1;
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_r", out_r, '0);
        chk("rst_out_tag", out_tag, '0);
        chk("rst_in_ready", in_ready, 1'b1);
        @(posedge clock); #1 reset_n = 1'b1;
        @(posedge clock); #1;

        // Directed: 2^32 mod Q times 1234, zero, (Q-1)^2, -(Q-1)*(Q-1)
        a = {32'(-(QC - 1)), 32'(QC - 1), 32'd0, 32'(MONTC)};
        b = {32'(QC - 1),    32'(QC - 1), 32'(QC - 1), 32'd1234};
        send(a, b);
        cnt = 1;
        while (cnt < 20) begin
            @(negedge clock);
            if (out_valid) break;
            @(posedge clock); #1;
            cnt++;
        end
        chk("latency", cnt, LAT);
        if (CANON)
            chk("lane0_mont1234", out_r[31:0], 32'd1234);
        else
            chk("lane0_mont1234", (out_r[31:0] == 32'd1234) || (out_r[31:0] == 32'(1234 - QC)), 1'b1);
        chk("lane1_zero", out_r[63:32], 32'd0);
        @(posedge clock); #1;
        wait_drain();

        // Full-rate random stream: one accept per cycle
        start = cyc;
        for (int i = 0; i < 1000; i++) send(rand_vec(), rand_vec());
        chk("throughput_cycles", cyc - start, 1000);
        wait_drain();

        // Burst into a stalled output
        out_ready = 1'b0;
        accepted  = 0;
        start     = out_cnt;
        fork
            begin
                for (int i = 0; i < 8; i++) send(rand_vec(), rand_vec());
            end
            begin
                repeat (10) @(posedge clock);
                @(negedge clock);
                chk("stall_in_ready", in_ready, 1'b0);
                chk("stall_accepted", accepted, LAT);
                chk("stall_out_valid", out_valid, 1'b1);
                @(posedge clock); #1 out_ready = 1'b1;
            end
        join
        wait_drain();
        chk("burst_out_count", out_cnt - start, 8);

        // Random valid/ready toggling
        done5 = 1'b0;
        start = out_cnt;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    repeat ($urandom_range(0, 1)) begin
                        @(posedge clock); #1;
                    end
                    send(rand_vec(), rand_vec());
                end
                done5 = 1'b1;
            end
            begin
                while (!done5) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clock); #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();
        chk("random_out_count", out_cnt - start, 60);

        // Reset with three sets in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(rand_vec(), rand_vec());
        repeat (LAT) begin
            @(posedge clock); #1;
        end
        chk("pre_rst_out_valid", out_valid, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 1'b0);
        chk("async_rst_out_r", out_r, '0);
        exp_q.delete();
        out0 = out_cnt;
        @(posedge clock); #1;
        @(posedge clock); #1 reset_n = 1'b1;
        out_ready = 1'b1;
        repeat (12) begin
            @(posedge clock); #1;
        end
        chk("post_rst_no_output", out_cnt - out0, 0);
        chk("post_rst_in_ready", in_ready, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
